// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared types and constants for the fetch front end
package if_fetch_unit_pkg;

    localparam int DEF_WIDTH = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int INC_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction memory and decode-side handshake bundle
interface if_fetch_unit_if
    import if_fetch_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] inst_pc;
    logic             inst_valid;
    logic             inst_ready;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst, inst_pc, inst_valid,
        input  inst_ready
    );

    // Memory plus decode side
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst, inst_pc, inst_valid,
        output inst_ready
    );

endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end with one-entry output register
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
    parameter int               INC      = INC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] next_pc,
    input  logic             redirect,
    output logic [WIDTH-1:0] pc_plus4,
    if_fetch_unit_if.master  bus
);

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] req_addr;
    logic             slot_free;

    assign pc_plus4      = pc + WIDTH'(INC);
    assign slot_free     = !bus.inst_valid || bus.inst_ready;
    assign bus.imem_req  = (state != S_IDLE);
    assign bus.imem_addr = req_addr;

    // Fetch sequencing, PC update and the decode-facing output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            req_addr       <= RESET_PC;
            bus.inst       <= '0;
            bus.inst_pc    <= '0;
            bus.inst_valid <= 1'b0;
        end else begin
            // A consumed instruction leaves; a redirect flushes the younger buffered one
            if ((bus.inst_valid && bus.inst_ready) || redirect) begin
                bus.inst_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (redirect) begin
                        pc <= next_pc;
                    end else if (slot_free) begin
                        req_addr <= pc;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        // The memory still owes an answer if it has not acked yet
                        pc    <= next_pc;
                        state <= bus.imem_ack ? S_IDLE : S_DROP;
                    end else if (bus.imem_ack) begin
                        bus.inst       <= bus.imem_rdata;
                        bus.inst_pc    <= req_addr;
                        bus.inst_valid <= 1'b1;
                        pc             <= next_pc;
                        state          <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (redirect) begin
                        pc <= next_pc;
                    end
                    if (bus.imem_ack) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for the fetch front end
module tb_if_fetch_unit;

    localparam int          W   = 32;
    localparam logic [31:0] RPC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;

    if_fetch_unit_if #(.WIDTH(W)) bus ();

    if_fetch_unit #(.WIDTH(W), .RESET_PC(RPC), .INC(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .next_pc  (next_pc),
        .redirect (redirect),
        .pc_plus4 (pc_plus4),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Parent's next-PC mux: a0 = pc_plus4, a1 = branch target, s = redirect
    assign next_pc = redirect ? target : pc_plus4;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    // Memory responder state
    int lat_cfg = 0;
    int cur_lat = 0;
    int wcnt    = 0;
    bit mem_busy = 1'b0;
    bit ack_q    = 1'b0;

    task automatic step(input bit rd, input logic [31:0] tgt, input bit rdy, input bit rs);
        @(posedge clk);
        #1;
        if (ack_q || rst) mem_busy = 1'b0;
        rst = rs;
        redirect = rd;
        target = tgt;
        bus.inst_ready = rdy;
        if (bus.imem_req && !mem_busy) begin
            mem_busy = 1'b1;
            wcnt = 0;
            cur_lat = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
        end else if (mem_busy) begin
            wcnt++;
        end
        ack_q = mem_busy && (wcnt >= cur_lat);
        bus.imem_ack = ack_q;
        bus.imem_rdata = ack_q ? memf(bus.imem_addr) : $urandom;
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    // Reference model: program-order fetch address and the expected delivery queue
    ent_t        sb[$];
    logic [31:0] exp_pc = RPC;
    logic [31:0] fl_addr = '0;
    bit          in_flight = 1'b0;
    bit          live = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc = RPC;
            in_flight = 1'b0;
            live = 1'b0;
            sb.delete();
        end else begin
            if (in_flight) begin
                chk(bus.imem_req && bus.imem_addr == fl_addr, "req_stable", bus.imem_addr, fl_addr);
            end else if (bus.imem_req) begin
                chk(bus.imem_addr == exp_pc, "req_addr", bus.imem_addr, exp_pc);
                in_flight = 1'b1;
                live = 1'b1;
                fl_addr = bus.imem_addr;
            end
            if (in_flight && bus.imem_ack) begin
                in_flight = 1'b0;
                if (live && !redirect) begin
                    chk(sb.size() == 0, "sb_empty_at_ack", 32'(sb.size()), 32'h0);
                    chk(!bus.inst_valid, "slot_free_at_ack", 32'(bus.inst_valid), 32'h0);
                    sb.push_back('{pc: fl_addr, data: memf(fl_addr)});
                    exp_pc = fl_addr + 32'd4;
                end
            end
            if (redirect) begin
                exp_pc = target;
                live = 1'b0;
                sb.delete();
            end
        end
    end

    // Output monitor: pops on every real transfer, checks hold under backpressure
    bit          hold_v = 1'b0;
    logic [31:0] hold_inst = '0;
    logic [31:0] hold_pc = '0;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk(bus.inst_valid && bus.inst == hold_inst && bus.inst_pc == hold_pc,
                    "inst_hold", bus.inst_pc, hold_pc);
            end
            if (bus.inst_valid && bus.inst_ready && !redirect) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "spurious_inst", bus.inst_pc, 32'h0);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    chk(bus.inst_pc == e.pc, "inst_pc", bus.inst_pc, e.pc);
                    chk(bus.inst == e.data, "inst_data", bus.inst, e.data);
                end
            end
            hold_v = bus.inst_valid && !bus.inst_ready && !redirect;
            hold_inst = bus.inst;
            hold_pc = bus.inst_pc;
        end
    end

    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.inst_ready = 1'b0;

        // Reset values
        do_reset();
        chk(!bus.imem_req, "rst_req", 32'(bus.imem_req), 32'h0);
        chk(bus.imem_addr == RPC, "rst_addr", bus.imem_addr, RPC);
        chk(bus.inst == 32'h0, "rst_inst", bus.inst, 32'h0);
        chk(bus.inst_pc == 32'h0, "rst_inst_pc", bus.inst_pc, 32'h0);
        chk(!bus.inst_valid, "rst_valid", 32'(bus.inst_valid), 32'h0);
        chk(pc_plus4 == RPC + 32'd4, "rst_pc_plus4", pc_plus4, RPC + 32'd4);

        // Zero-wait memory: 0,4,8,C on alternate cycles
        lat_cfg = 0;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            if (i % 2 == 0)
                chk(bus.imem_req && bus.imem_addr == 32'(2 * i), "zw_req", bus.imem_addr, 32'(2 * i));
            else
                chk(!bus.imem_req && bus.inst_valid && bus.inst_pc == 32'(2 * (i - 1)),
                    "zw_inst", bus.inst_pc, 32'(2 * (i - 1)));
        end

        // Three wait cycles: request and address stable, single capture
        do_reset();
        lat_cfg = 3;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            chk(bus.imem_req && bus.imem_addr == 32'h0 && !bus.inst_valid, "slow_wait", bus.imem_addr, 32'h0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk(!bus.imem_req && bus.inst_valid && bus.inst == memf(32'h0), "slow_capture", bus.inst, memf(32'h0));
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk(bus.imem_req && bus.imem_addr == 32'h4, "slow_next", bus.imem_addr, 32'h4);

        // Backpressure: no fetch while the slot is held
        do_reset();
        lat_cfg = 0;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            chk(!bus.imem_req && bus.inst_valid && bus.inst == memf(32'h0), "bp_hold", bus.inst, memf(32'h0));
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk(!bus.imem_req, "bp_release", 32'(bus.imem_req), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk(bus.imem_req && bus.imem_addr == 32'h4, "bp_next", bus.imem_addr, 32'h4);

        // Redirect while waiting, no ack: old request completes, then fetch at target
        do_reset();
        lat_cfg = 3;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h100, 1'b1, 1'b0);
        begin
            bit found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
                step(1'b0, 32'h0, 1'b1, 1'b0);
                chk(!bus.inst_valid, "drop_no_stale", 32'(bus.inst_valid), 32'h0);
                if (bus.imem_req && bus.imem_addr == 32'h100) found = 1'b1;
            end
            chk(found, "drop_refetch", 32'(found), 32'h1);
        end

        // Redirect with ack, then redirect flushing a buffered instruction
        do_reset();
        lat_cfg = 0;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h200, 1'b1, 1'b0);
        chk(bus.imem_req && bus.imem_ack, "coinc_ack", 32'(bus.imem_ack), 32'h1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk(!bus.inst_valid && !bus.imem_req, "coinc_discard", 32'(bus.inst_valid), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk(bus.imem_req && bus.imem_addr == 32'h200, "coinc_target", bus.imem_addr, 32'h200);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk(bus.inst_valid && bus.inst_pc == 32'h200, "buf_live", bus.inst_pc, 32'h200);
        step(1'b1, 32'h300, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk(!bus.inst_valid, "buf_flushed", 32'(bus.inst_valid), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk(bus.imem_req && bus.imem_addr == 32'h300, "flush_target", bus.imem_addr, 32'h300);

        // Reset mid-wait, then wrap of pc_plus4 from the top of the address space
        do_reset();
        lat_cfg = 3;
        step(1'b1, 32'h7FFC, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk(pc_plus4 == 32'h8000, "pc_7ffc", pc_plus4, 32'h8000);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk(bus.imem_req && bus.imem_addr == 32'h7FFC, "req_7ffc", bus.imem_addr, 32'h7FFC);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk(!bus.imem_req && pc_plus4 == RPC + 32'd4, "midwait_rst", pc_plus4, RPC + 32'd4);
        step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk(pc_plus4 == 32'h0, "wrap_plus4", pc_plus4, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk(bus.imem_req && bus.imem_addr == 32'hFFFF_FFFC, "wrap_req", bus.imem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomised traffic against the reference model
        lat_cfg = -1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(0, 9) == 0, t, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end
        chk(sb.size() <= 1, "sb_drain", 32'(sb.size()), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
